hazard_control_unit: RTL

- Parametrised hazard controller for the 5-stage pipeline; replaces the single-case load-use detector.
- Detects load-use hazards against EX and, when configured, MEM.
- Freezes the front end while the multi-cycle multiply/divide unit (MDU) occupies EX.
- Flushes wrong-path instructions on a taken branch resolved in EX.
- Keeps saturating stall and flush counters for performance analysis.
- Sits between the ID stage and the IF/ID, ID/EX and EX/MEM pipeline registers plus the PC register.

---
 rtl/hazard_control_unit_if.sv | 39 +++
 rtl/hazard_control_unit.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/hazard_control_unit_if.sv
// Bundle between the ID-stage hazard controller and the pipeline registers it steers.
// The slave side is the controller; the master side is the pipeline (or a bench).
interface hazard_control_unit_if #(
   parameter int REG_ADDR_W = 5,
   parameter int CNT_W      = 16
);
   logic [REG_ADDR_W-1:0] id_rs1;
   logic [REG_ADDR_W-1:0] id_rs2;
   logic                  id_rs1_used;
   logic                  id_rs2_used;
   logic [REG_ADDR_W-1:0] ex_rd;
   logic                  ex_mem_read;
   logic [REG_ADDR_W-1:0] mem_rd;
   logic                  mem_mem_read;
   logic                  ex_mdu_op;
   logic                  ex_branch_taken;
   logic                  pc_write;
   logic                  if_id_write;
   logic                  if_id_flush;
   logic                  id_ex_bubble;
   logic                  ex_hold;
   logic                  mdu_busy;
   logic [CNT_W-1:0]      stall_count;
   logic [CNT_W-1:0]      flush_count;

   modport slave (
      input  id_rs1, id_rs2, id_rs1_used, id_rs2_used, ex_rd, ex_mem_read,
             mem_rd, mem_mem_read, ex_mdu_op, ex_branch_taken,
      output pc_write, if_id_write, if_id_flush, id_ex_bubble, ex_hold,
             mdu_busy, stall_count, flush_count
   );

   modport master (
      output id_rs1, id_rs2, id_rs1_used, id_rs2_used, ex_rd, ex_mem_read,
             mem_rd, mem_mem_read, ex_mdu_op, ex_branch_taken,
      input  pc_write, if_id_write, if_id_flush, id_ex_bubble, ex_hold,
             mdu_busy, stall_count, flush_count
   );
endinterface

// File: rtl/hazard_control_unit.sv
// Hazard controller for the 5-stage pipeline: load-use stalls, MDU front-end freeze,
// taken-branch flush, and saturating stall/flush counters.
module hazard_control_unit #(
   parameter int REG_ADDR_W  = 5,
   parameter int LOAD_STAGES = 1,
   parameter int MDU_LATENCY = 4,
   parameter int CNT_W       = 16
) (
   input logic                  clk,
   input logic                  reset,
   hazard_control_unit_if.slave bus
);
   localparam int CW = $clog2(MDU_LATENCY) + 1;
   localparam logic [CW-1:0]         C_CNT_ZERO = CW'(0);
   localparam logic [CW-1:0]         C_CNT_ONE  = CW'(1);
   localparam logic [CW-1:0]         C_CNT_LAST = CW'(MDU_LATENCY - 1);
   localparam logic [REG_ADDR_W-1:0] C_R_ZERO   = REG_ADDR_W'(0);
   localparam logic [CNT_W-1:0]      C_PC_ZERO  = CNT_W'(0);
   localparam logic [CNT_W-1:0]      C_PC_ONE   = CNT_W'(1);
   localparam logic [CNT_W-1:0]      C_PC_MAX   = {CNT_W{1'b1}};
   localparam logic                  C_CHK_MEM  = (LOAD_STAGES == 2);
   localparam logic                  C_MDU_HOLD = (MDU_LATENCY > 1);

   typedef enum logic {S_IDLE = 1'b0, S_BUSY = 1'b1} mdu_state_t;

   mdu_state_t       r_state;
   mdu_state_t       w_state_nxt;
   logic [CW-1:0]    r_cnt;
   logic [CW-1:0]    w_cnt_nxt;
   logic             w_hold_raw;
   logic [CNT_W-1:0] r_stall_cnt;
   logic [CNT_W-1:0] r_flush_cnt;

   logic w_rs1_ex, w_rs2_ex, w_rs1_mem, w_rs2_mem;
   logic w_load_ex, w_load_mem, w_load_hz;
   logic w_pc_write, w_if_id_write, w_if_id_flush, w_id_ex_bubble, w_ex_hold;
   logic w_stall_evt, w_flush_evt;

   // Register 0 is hardwired zero, so neither side of a match may be x0.
   assign w_rs1_ex   = bus.id_rs1_used && (bus.id_rs1 != C_R_ZERO) && (bus.id_rs1 == bus.ex_rd);
   assign w_rs2_ex   = bus.id_rs2_used && (bus.id_rs2 != C_R_ZERO) && (bus.id_rs2 == bus.ex_rd);
   assign w_rs1_mem  = bus.id_rs1_used && (bus.id_rs1 != C_R_ZERO) && (bus.id_rs1 == bus.mem_rd);
   assign w_rs2_mem  = bus.id_rs2_used && (bus.id_rs2 != C_R_ZERO) && (bus.id_rs2 == bus.mem_rd);
   assign w_load_ex  = bus.ex_mem_read && (bus.ex_rd != C_R_ZERO) && (w_rs1_ex || w_rs2_ex);
   assign w_load_mem = C_CHK_MEM && bus.mem_mem_read && (bus.mem_rd != C_R_ZERO)
                       && (w_rs1_mem || w_rs2_mem);
   assign w_load_hz  = w_load_ex || w_load_mem;

   // MDU FSM next state: hold for MDU_LATENCY-1 cycles, release on the completion cycle.
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_hold_raw  = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (bus.ex_mdu_op && C_MDU_HOLD) begin
               w_state_nxt = S_BUSY;
               w_cnt_nxt   = C_CNT_ONE;
               w_hold_raw  = 1'b1;
            end else begin
               w_cnt_nxt   = C_CNT_ZERO;
            end
         end
         S_BUSY: begin
            if (!bus.ex_mdu_op) begin
               w_state_nxt = S_IDLE;
               w_cnt_nxt   = C_CNT_ZERO;
            end else if (r_cnt < C_CNT_LAST) begin
               w_cnt_nxt   = r_cnt + C_CNT_ONE;
               w_hold_raw  = 1'b1;
            end else begin
               w_state_nxt = S_IDLE;
               w_cnt_nxt   = C_CNT_ZERO;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = C_CNT_ZERO;
         end
      endcase
   end

   // Priority mux for pipeline control; reset forces idle values with no clock needed.
   always_comb begin
      w_pc_write     = 1'b1;
      w_if_id_write  = 1'b1;
      w_if_id_flush  = 1'b0;
      w_id_ex_bubble = 1'b0;
      w_ex_hold      = 1'b0;
      w_stall_evt    = 1'b0;
      w_flush_evt    = 1'b0;
      if (!reset) begin
         w_ex_hold      = 1'b0;
      end else if (w_hold_raw) begin
         w_pc_write     = 1'b0;
         w_if_id_write  = 1'b0;
         w_ex_hold      = 1'b1;
         w_stall_evt    = 1'b1;
      end else if (bus.ex_branch_taken) begin
         w_if_id_flush  = 1'b1;
         w_id_ex_bubble = 1'b1;
         w_flush_evt    = 1'b1;
      end else if (w_load_hz) begin
         w_pc_write     = 1'b0;
         w_if_id_write  = 1'b0;
         w_id_ex_bubble = 1'b1;
         w_stall_evt    = 1'b1;
      end else begin
         w_pc_write     = 1'b1;
         w_if_id_write  = 1'b1;
      end
   end

   // MDU state and occupancy count.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= S_IDLE;
         r_cnt   <= C_CNT_ZERO;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   // Saturating performance counters; they stop at all-ones rather than wrapping.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_stall_cnt <= C_PC_ZERO;
         r_flush_cnt <= C_PC_ZERO;
      end else begin
         if (w_stall_evt && (r_stall_cnt != C_PC_MAX)) begin
            r_stall_cnt <= r_stall_cnt + C_PC_ONE;
         end
         if (w_flush_evt && (r_flush_cnt != C_PC_MAX)) begin
            r_flush_cnt <= r_flush_cnt + C_PC_ONE;
         end
      end
   end

   assign bus.pc_write     = w_pc_write;
   assign bus.if_id_write  = w_if_id_write;
   assign bus.if_id_flush  = w_if_id_flush;
   assign bus.id_ex_bubble = w_id_ex_bubble;
   assign bus.ex_hold      = w_ex_hold;
   assign bus.mdu_busy     = (r_state == S_BUSY);
   assign bus.stall_count  = r_stall_cnt;
   assign bus.flush_count  = r_flush_cnt;
endmodule
